// File: rtl/debounce_pkg.sv
// debounce_pkg: types and helpers shared by the debounce bank.
//   hold_state_t : per-channel long-press state
//   cnt_w()      : counter width able to hold 0..max_val (never less than 1 bit)
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    REPEAT,
    DONE
  } hold_state_t;

  // A zero max still needs a 1-bit counter so declarations stay legal.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one button channel.
//   clk, rst    : clock, async active-high reset
//   noisy_in    : raw asynchronous button level
//   db_out      : debounced level
//   rise_pulse  : one cycle, on the edge db_out goes 0->1
//   fall_pulse  : one cycle, on the edge db_out goes 1->0
//   hold_pulse  : one cycle long-press / auto-repeat pulse
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int COUNT_MAX     = 250_000,
  parameter int HOLD_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic noisy_in,
  output logic db_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic hold_pulse
);

  localparam int CW   = cnt_w(COUNT_MAX);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = cnt_w(HMAX);

  // Compare against N-1: the edge that sees count N-1 is the N-th one.
  localparam logic [CW-1:0] CNT_LAST  = CW'(COUNT_MAX - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES   > 0) ? HOLD_CYCLES   - 1 : 0);
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   db_q, rise_q, fall_q;
  logic                   s, mismatch, accept, rise_evt, fall_evt;

  hold_state_t            state_q, state_d;
  logic [HW-1:0]          hcnt_q, hcnt_d, hcnt_inc;
  logic                   hold_q, hold_d;

  // synchroniser + debounce counter + edge pulses
  assign s        = sync_q[SYNC_STAGES-1];
  assign mismatch = s ^ db_q;
  assign accept   = mismatch && (cnt_q == CNT_LAST);
  assign rise_evt = accept &&  s;
  assign fall_evt = accept && !s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in};
      rise_q <= rise_evt;
      fall_q <= fall_evt;
      if (accept) db_q <= s;
      // any agreement restarts the count; acceptance also restarts it
      if (!mismatch || accept) cnt_q <= '0;
      else                     cnt_q <= cnt_q + CW'(1);
    end
  end

  // hold FSM
  assign hcnt_inc = (hcnt_q == '1) ? hcnt_q : hcnt_q + HW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    hold_d  = 1'b0;
    if (fall_evt) begin
      // fall beats a coinciding hold/repeat due edge
      state_d = IDLE;
      hcnt_d  = hcnt_inc;
    end else if (rise_evt) begin
      state_d = PRESSED;
      hcnt_d  = '0;
    end else if (!db_q) begin
      state_d = IDLE;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        PRESSED: begin
          if ((HOLD_CYCLES > 0) && (hcnt_q == HOLD_LAST)) begin
            hold_d  = 1'b1;
            hcnt_d  = '0;
            state_d = (REPEAT_CYCLES > 0) ? REPEAT : DONE;
          end else begin
            hcnt_d  = hcnt_inc;
          end
        end
        REPEAT: begin
          if (hcnt_q == REP_LAST) begin
            hold_d = 1'b1;
            hcnt_d = '0;
          end else begin
            hcnt_d = hcnt_inc;
          end
        end
        default: hcnt_d = hcnt_inc;
      endcase
    end
  end

  assign db_out     = db_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign hold_pulse = (HOLD_CYCLES > 0) && hold_q;

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent button conditioners.
//   clk, rst    : clock, async active-high reset
//   noisy_in    : raw button levels, one bit per channel
//   db_out      : debounced levels
//   rise_pulse  : per-channel 0->1 pulse
//   fall_pulse  : per-channel 1->0 pulse
//   hold_pulse  : per-channel long-press / repeat pulse
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int COUNT_MAX     = 250_000,
  parameter int HOLD_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] db_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] hold_pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .COUNT_MAX    (COUNT_MAX),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .noisy_in  (noisy_in[i]),
      .db_out    (db_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i]),
      .hold_pulse(hold_pulse[i])
    );
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel push-button conditioner, successor to the single-channel debouncer. Each of `N_CH` active-high inputs gets its own synchroniser and counter-based debounce. Each channel also produces single-cycle rise and fall pulses and a long-press pulse with optional auto-repeat. The block sits between the board buttons and the SPI master control logic; downstream logic consumes pulses directly and needs no edge detectors.

## Interface
- `N_CH`, 4: number of independent channels, ≥1.
- `SYNC_STAGES`, 2: synchroniser flops per channel, ≥2.
- `COUNT_MAX`, 250_000: consecutive mismatching cycles required to accept a new level, ≥1 (~2.5 ms @ 100 MHz).
- `HOLD_CYCLES`, 100_000_000: cycles `db_out` must stay high before `hold_pulse`. 0 disables hold and repeat.
- `REPEAT_CYCLES`, 0: auto-repeat period after the first hold pulse. 0 means a single hold pulse per press.
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `noisy_in` in N_CH: raw button levels, asynchronous to `clk`.
- `db_out` out N_CH: debounced level per channel.
- `rise_pulse` out N_CH: one-cycle pulse when `db_out` goes 0→1.
- `fall_pulse` out N_CH: one-cycle pulse when `db_out` goes 1→0.
- `hold_pulse` out N_CH: one-cycle long-press / repeat pulse.

## Operation
- Channels are fully independent; the behaviour below applies per bit.
- Synchroniser: `SYNC_STAGES` flops in a chain. The last stage is the sampled level `s`.
- Debounce counter `cnt`:
  - Width is `$clog2(COUNT_MAX+1)`.
  - On any edge where `s == db_out`, `cnt` goes to 0.
  - On an edge where `s != db_out`, `cnt` increments. If that edge is the `COUNT_MAX`-th consecutive mismatch, `db_out` takes `s` and `cnt` goes to 0.
  - `cnt` never exceeds `COUNT_MAX`.
- Edge pulses:
  - `rise_pulse` and `fall_pulse` are registered. They update on the same edge that changes `db_out` and are high for exactly that one cycle.
  - They are never both high.
- Hold counter `hcnt`:
  - Width is `$clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1)`.
  - Cleared on the edge where `db_out` rises, and while `db_out` is 0.
  - Increments each edge while `db_out` is 1.
- Hold states per channel:
  - IDLE: `db_out`=0.
  - PRESSED: waiting `HOLD_CYCLES`.
  - REPEAT: counting `REPEAT_CYCLES`.
  - DONE: held, no further pulses.
- Hold transitions:
  - IDLE→PRESSED on rise.
  - PRESSED→REPEAT (if `REPEAT_CYCLES`>0) or →DONE, with `hold_pulse`, when `hcnt` reaches `HOLD_CYCLES`.
  - In REPEAT, pulse and reload every `REPEAT_CYCLES`.
  - Any state →IDLE on fall, with no `hold_pulse` on that edge.
- `HOLD_CYCLES`=0: the state machine stays in IDLE/PRESSED and `hold_pulse` is tied to 0.
- Counters saturate; no wrap-around anywhere.

## Timing
- Reset (async assert, sync release): all sync flops, `cnt`, `hcnt` = 0; state IDLE; `db_out`, `rise_pulse`, `fall_pulse`, `hold_pulse` = 0.
- Press latency: counting the first edge that samples a new stable input level as edge 1, `db_out` changes on edge `SYNC_STAGES+COUNT_MAX`. `rise_pulse`/`fall_pulse` assert on that same edge.
- An input held high through reset release produces a normal rise after the full latency.
- Glitches: any input excursion shorter than `COUNT_MAX` sampled cycles produces no output change. A bounce back mid-count restarts the count from 0.
- Hold timing: with rise on edge R, the first `hold_pulse` is on edge R+`HOLD_CYCLES`. Repeats follow on R+`HOLD_CYCLES`+k·`REPEAT_CYCLES`.
- Fall coinciding with a hold/repeat due edge: the fall wins, and `hold_pulse` stays 0.
- Reset mid-count or mid-hold: immediate return to reset values. No pulses are emitted on reset.

## Structure
- Package `debounce_pkg`:
  - hold-state enum `hold_state_t` (IDLE, PRESSED, REPEAT, DONE);
  - a `clog2`-based width function shared by the counter declarations.
- Sub-module `debounce_chan`: one channel (synchroniser, debounce counter, edge pulses, hold FSM), same parameters minus `N_CH`.
- `debounce_bank` is a generate loop of `N_CH` instances of `debounce_chan`.

## Test plan
Benches run with N_CH=2, SYNC_STAGES=2, COUNT_MAX=4, HOLD_CYCLES=10, REPEAT_CYCLES=3 unless noted.
- Clean press on ch0 → `db_out[0]` and `rise_pulse[0]` high on edge 6 after the first sampling edge. Pulse lasts 1 cycle. ch1 stays 0.
- Bounce: high 3 cycles, low 1, high stable → no change from the 3-cycle burst. `db_out` rises 6 edges after the final transition.
- Hold: press held 20 cycles after rise edge R → `hold_pulse` on R+10, R+13, R+16, R+19. Release → `fall_pulse` after 6 edges, with no hold pulse on or after the fall edge.
- REPEAT_CYCLES=0, press held 30 cycles → exactly one `hold_pulse`, at R+10.
- `rst` asserted mid-count and mid-hold → all outputs 0 immediately, with no spurious pulse after release. An input held high through release → rise 6 edges after release.
- Simultaneous press of ch0 and release of ch1 → independent `rise_pulse[0]` and `fall_pulse[1]` on the same edge.
